// File: rtl/dut_s2mm_packer.sv
`timescale 1ns/1ps
// Packs pairs of samples into 32-bit AXI-Stream beats framed by tlast, buffered in a FWFT FIFO.
// Optional counter test-pattern source is compiled in when PACKER_TESTPAT_EN is defined.
module dut_s2mm_packer #(
  parameter int SAMPLE_W   = 16,
  parameter int PKT_BEATS  = 256,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  s_valid,
`ifdef PACKER_TESTPAT_EN
  input  logic                  testpat_sel,
`endif
  output logic [2*SAMPLE_W-1:0] m_axis_tdata,
  output logic [3:0]            m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           drop_cnt,
  output logic [31:0]           pkt_cnt,
  output logic                  overflow,
  output logic                  busy
);

  localparam int DATA_W = 2 * SAMPLE_W;
  localparam int ENT_W  = DATA_W + 5;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH_A, FLUSH_B} state_t;

  state_t              state_reg;
  logic [SAMPLE_W-1:0] low_reg;
  logic                half_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic                stage_valid_reg;
  logic [ENT_W-1:0]    stage_ent_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                out_valid_reg;
  logic [ENT_W-1:0]    out_ent_reg;
  logic [31:0]         drop_cnt_reg;
  logic [31:0]         pkt_cnt_reg;
  logic                overflow_reg;
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];

  logic [SAMPLE_W-1:0] sample_in;
  logic                accept;
  logic                last_flag;
  logic [ENT_W-1:0]    formed_ent;
  logic                full;
  logic                pop;
  logic                push_req;
  logic [ENT_W-1:0]    push_ent;
  logic                push;
  logic                drop;
  logic                mem_has_data;
  logic                mem_load;

`ifdef PACKER_TESTPAT_EN
  logic [15:0] tp_cnt_reg;
  assign sample_in = testpat_sel ? SAMPLE_W'(tp_cnt_reg) : s_data;
`else
  assign sample_in = s_data;
`endif

  assign accept     = (state_reg == RUN) && enable && s_valid;
  assign last_flag  = (beat_cnt_reg == BEAT_W'(PKT_BEATS - 1));
  assign formed_ent = {last_flag, 4'hF, sample_in, low_reg};
  assign full       = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop        = out_valid_reg && m_axis_tready;

  // count_reg includes the output register, so the memory holds count minus that entry.
  assign mem_has_data = (count_reg != {{(CNT_W-1){1'b0}}, out_valid_reg});
  assign mem_load     = (!out_valid_reg || pop) && mem_has_data;

  always_comb begin
    push_req = 1'b0;
    push_ent = stage_ent_reg;
    case (state_reg)
      RUN:     push_req = accept && half_reg && stage_valid_reg;
      FLUSH_A: begin
        push_req = stage_valid_reg;
        push_ent = {stage_ent_reg[ENT_W-1] | ~half_reg, stage_ent_reg[ENT_W-2:0]};
      end
      FLUSH_B: begin
        push_req = 1'b1;
        push_ent = {1'b1, 4'h3, {SAMPLE_W{1'b0}}, low_reg};
      end
      default: ;
    endcase
  end

  // Flush pushes stall instead of dropping, so only RUN can lose a beat.
  assign push = push_req && !full;
  assign drop = push_req && full && (state_reg == RUN);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      low_reg         <= '0;
      half_reg        <= 1'b0;
      beat_cnt_reg    <= '0;
      stage_valid_reg <= 1'b0;
      stage_ent_reg   <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      out_valid_reg   <= 1'b0;
      out_ent_reg     <= '0;
      drop_cnt_reg    <= '0;
      pkt_cnt_reg     <= '0;
      overflow_reg    <= 1'b0;
`ifdef PACKER_TESTPAT_EN
      tp_cnt_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) state_reg <= RUN;
`ifdef PACKER_TESTPAT_EN
          tp_cnt_reg <= '0;
`endif
        end
        RUN: begin
          if (!enable) begin
            state_reg <= FLUSH_A;
          end else if (accept) begin
`ifdef PACKER_TESTPAT_EN
            tp_cnt_reg <= tp_cnt_reg + 16'd1;
`endif
            if (!half_reg) begin
              low_reg  <= sample_in;
              half_reg <= 1'b1;
            end else begin
              stage_ent_reg   <= formed_ent;
              stage_valid_reg <= 1'b1;
              half_reg        <= 1'b0;
              beat_cnt_reg    <= last_flag ? '0 : beat_cnt_reg + BEAT_W'(1);
            end
          end
        end
        FLUSH_A: begin
          if (!stage_valid_reg || !full) begin
            stage_valid_reg <= 1'b0;
            if (half_reg) begin
              state_reg <= FLUSH_B;
            end else begin
              state_reg    <= IDLE;
              beat_cnt_reg <= '0;
            end
          end
        end
        FLUSH_B: begin
          if (!full) begin
            state_reg    <= IDLE;
            half_reg     <= 1'b0;
            beat_cnt_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

      if (mem_load) begin
        out_ent_reg   <= mem[rd_ptr_reg];
        out_valid_reg <= 1'b1;
        rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end

      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 32'hFFFF_FFFF) drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
      if (pop && out_ent_reg[ENT_W-1]) pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
    end
  end

  assign m_axis_tdata  = out_ent_reg[DATA_W-1:0];
  assign m_axis_tkeep  = out_ent_reg[DATA_W+3:DATA_W];
  assign m_axis_tlast  = out_ent_reg[ENT_W-1];
  assign m_axis_tvalid = out_valid_reg;
  assign drop_cnt      = drop_cnt_reg;
  assign pkt_cnt       = pkt_cnt_reg;
  assign overflow      = overflow_reg;
  assign busy          = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_dut_s2mm_packer.sv
`timescale 1ns/1ps
// Directed bench for dut_s2mm_packer: packing, backpressure, overflow, odd/even flush, reset.
module tb_dut_s2mm_packer;
  localparam int PKT = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic [31:0] drop_cnt;
  logic [31:0] pkt_cnt;
  logic        overflow;
  logic        busy;
`ifdef PACKER_TESTPAT_EN
  logic        testpat_sel = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] beat_q[$];

  always #5 clk = ~clk;

  dut_s2mm_packer #(.SAMPLE_W(16), .PKT_BEATS(PKT), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
`ifdef PACKER_TESTPAT_EN
    .testpat_sel(testpat_sel),
`endif
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt), .overflow(overflow), .busy(busy)
  );

  // Inputs change only just after posedge, so a handshake seen here completes at the next edge.
  always @(negedge clk)
    if (rst_n && m_axis_tvalid && m_axis_tready)
      beat_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    enable  = 1'b1;
    s_valid = 1'b0;
    tick();
  endtask

  task automatic send(input logic [15:0] base, input int from, input int to, output int first_v);
    first_v = -1;
    for (int i = from; i < to; i++) begin
      s_data  = base + 16'(i);
      s_valid = 1'b1;
      tick();
      if (first_v < 0 && m_axis_tvalid) first_v = i;
    end
    s_valid = 1'b0;
  endtask

  task automatic stop_and_drain(input string tag);
    int n = 0;
    enable  = 1'b0;
    s_valid = 1'b0;
    tick();
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, busy, 1'b0);
  endtask

  task automatic verify(input string tag, input logic [15:0] base, input int nbeats,
                        input int drop_lo, input int drop_n);
    int j = 0;
    int bad = 0;
    logic [15:0] lo_s;
    logic [36:0] exp;
    check({tag, "_count"}, beat_q.size(), nbeats - drop_n);
    for (int k = 0; k < nbeats; k++) begin
      if (k >= drop_lo && k < drop_lo + drop_n) continue;
      lo_s = base + 16'(2 * k);
      exp  = {((k % PKT == PKT - 1) || (k == nbeats - 1)) ? 1'b1 : 1'b0, 4'hF, lo_s + 16'd1, lo_s};
      if (j >= beat_q.size() || beat_q[j] !== exp) bad++;
      j++;
    end
    check({tag, "_seq"}, bad, 0);
    $display("[TB] %s: %0d beats received", tag, beat_q.size());
    beat_q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv;
    logic [36:0] head;

    // Reset state
    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tkeep", m_axis_tkeep, 4'h0);
    check("rst_drop", drop_cnt, 32'd0);
    check("rst_pkt", pkt_cnt, 32'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic packing, samples 0x0001..0x0200
    m_axis_tready = 1'b1;
    start();
    send(16'h0001, 0, 512, fv);
    check("latency", fv - 1, 3);
    stop_and_drain("basic");
    check("basic_beat0", beat_q.size() > 0 ? beat_q[0] : '0, {1'b0, 4'hF, 32'h0002_0001});
    check("basic_beat255", beat_q.size() > 255 ? beat_q[255] : '0, {1'b1, 4'hF, 32'h0200_01FF});
    verify("basic", 16'h0001, 256, 0, 0);
    check("basic_pkt", pkt_cnt, 32'd1);
    check("basic_drop", drop_cnt, 32'd0);

    // Backpressure: tready low for 20 cycles mid-packet; head is beat 48 during the stall
    start();
    for (int i = 0; i < 512; i++) begin
      s_data        = 16'h1000 + 16'(i);
      s_valid       = 1'b1;
      m_axis_tready = !(i >= 100 && i < 120);
      tick();
      if (i == 100 || i == 119) begin
        head = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        check($sformatf("bp_hold_%0d", i), head, {1'b0, 4'hF, 32'h1061_1060});
        check($sformatf("bp_valid_%0d", i), m_axis_tvalid, 1'b1);
      end
    end
    s_valid = 1'b0;
    m_axis_tready = 1'b1;
    stop_and_drain("bp");
    verify("bp", 16'h1000, 256, 0, 0);
    check("bp_drop", drop_cnt, 32'd0);
    check("bp_pkt", pkt_cnt, 32'd2);

    // Overflow: 200 samples into a stalled sink -> 64 stored, 1 staged, 35 dropped
    m_axis_tready = 1'b0;
    start();
    send(16'h2000, 0, 200, fv);
    tick();
    check("ovf_drop", drop_cnt, 32'd35);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
          {1'b1, 1'b0, 4'hF, 32'h2001_2000});
    m_axis_tready = 1'b1;
    tick();
    send(16'h2000, 200, 512, fv);
    stop_and_drain("ovf");
    verify("ovf", 16'h2000, 256, 64, 35);
    check("ovf_pkt", pkt_cnt, 32'd3);
    check("ovf_drop_after", drop_cnt, 32'd35);

    // Odd flush: A..E -> {B,A}, {D,C}, {0,E} partial with tlast
    start();
    for (int i = 0; i < 5; i++) begin
      s_data  = 16'(16'h1111 * (i + 1));
      s_valid = 1'b1;
      tick();
    end
    stop_and_drain("odd");
    check("odd_count", beat_q.size(), 3);
    check("odd_b0", beat_q.size() > 0 ? beat_q[0] : '0, {1'b0, 4'hF, 32'h2222_1111});
    check("odd_b1", beat_q.size() > 1 ? beat_q[1] : '0, {1'b0, 4'hF, 32'h4444_3333});
    check("odd_b2", beat_q.size() > 2 ? beat_q[2] : '0, {1'b1, 4'h3, 32'h0000_5555});
    check("odd_pkt", pkt_cnt, 32'd4);
    $display("[TB] odd: %0d beats received", beat_q.size());
    beat_q.delete();

    // Even flush into a full FIFO: FLUSH_A must stall, not drop
    m_axis_tready = 1'b0;
    start();
    send(16'h4000, 0, 130, fv);
    enable = 1'b0;
    repeat (10) tick();
    check("ff_busy", busy, 1'b1);
    check("ff_drop", drop_cnt, 32'd35);
    check("ff_head", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h4001_4000});
    m_axis_tready = 1'b1;
    stop_and_drain("ff");
    verify("ff", 16'h4000, 65, 0, 0);
    check("ff_pkt", pkt_cnt, 32'd5);
    check("ff_drop_after", drop_cnt, 32'd35);

    // Reset mid-packet after 10 beats, then a fresh capture
    start();
    send(16'h5000, 0, 20, fv);
    enable = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("mr_tvalid", m_axis_tvalid, 1'b0);
    check("mr_drop", drop_cnt, 32'd0);
    check("mr_pkt", pkt_cnt, 32'd0);
    check("mr_ovf", overflow, 1'b0);
    check("mr_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    beat_q.delete();
    start();
    send(16'h6000, 0, 512, fv);
    stop_and_drain("mr");
    verify("mr", 16'h6000, 256, 0, 0);
    check("mr_pkt_after", pkt_cnt, 32'd1);
    check("mr_drop_after", drop_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
